// File: rtl/swish_pkg.sv
// Shared types and constants for the swish activation scheduler.
package swish_pkg;

  // Job sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Output FIFO depth; also the read credit limit.
  localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/swish_lane_array.sv
// LANES parallel hard-swish units: y = x * relu6(x + 3) / 6, truncated to WIDTH bits.
module swish_lane_array #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned LANES         = 4,
  parameter int unsigned USE_SHIFT_ADD = 0
) (
  input  logic [LANES*WIDTH-1:0] data_i,
  output logic [LANES*WIDTH-1:0] data_o
);

  // Product x * [0..6] needs WIDTH + 3 bits signed; one spare bit for headroom.
  localparam int unsigned PW = WIDTH + 4;
  localparam logic signed [PW-1:0] Three = PW'(3);
  localparam logic signed [PW-1:0] Six   = PW'(6);
  localparam logic signed [PW-1:0] Zero  = '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WIDTH-1:0] x;
    logic signed [PW-1:0]    xe;
    logic signed [PW-1:0]    t;
    logic signed [PW-1:0]    r6;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    quo;

    assign x = data_i[i*WIDTH +: WIDTH];

    // Per-lane hard-swish; the divide is either exact or a shift-add estimate of 1/6.
    always_comb begin
      xe = PW'(x);
      t  = xe + Three;
      if (t < Zero) begin
        r6 = Zero;
      end else if (t > Six) begin
        r6 = Six;
      end else begin
        r6 = t;
      end
      prod = xe * r6;
      if (USE_SHIFT_ADD != 0) begin
        // 1/8 + 1/32 + 1/128 ~= 0.164
        quo = (prod >>> 3) + (prod >>> 5) + (prod >>> 7);
      end else begin
        quo = prod / Six;
      end
    end

    assign data_o[i*WIDTH +: WIDTH] = quo[WIDTH-1:0];
  end

endmodule

// File: rtl/swish_act_scheduler.sv
// Job sequencer: reads a tile from activation SRAM, applies hard-swish lane-wise, writes it back.
module swish_act_scheduler
  import swish_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned LANES         = 4,
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned LEN_W         = 12,
  parameter int unsigned USE_SHIFT_ADD = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ADDR_W-1:0]      cfg_src_base,
  input  logic [ADDR_W-1:0]      cfg_dst_base,
  input  logic [LEN_W-1:0]       cfg_len,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [LANES*WIDTH-1:0] rd_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [LANES*WIDTH-1:0] wr_data
);

  localparam int unsigned DataW = LANES * WIDTH;
  localparam int unsigned CntW  = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW  = $clog2(FifoDepth);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              inflight_q;

  logic [DataW-1:0]  fifo_mem_q [FifoDepth];
  logic [DataW-1:0]  fifo_mem_d [FifoDepth];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [DataW-1:0]  lane_out;
  logic              push;
  logic              pop;
  logic              last_rd;
  logic              last_wr;
  logic [CntW:0]     credit_used;

  swish_lane_array #(
    .WIDTH        (WIDTH),
    .LANES        (LANES),
    .USE_SHIFT_ADD(USE_SHIFT_ADD)
  ) u_lanes (
    .data_i(rd_data),
    .data_o(lane_out)
  );

  // Status and SRAM-facing outputs, all derived from registered state.
  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign wr_valid  = (count_q != '0);
  assign wr_data   = fifo_mem_q[rd_ptr_q];
  assign rd_addr   = src_q + ADDR_W'(rd_cnt_q);
  assign wr_addr   = dst_q + ADDR_W'(wr_cnt_q);

  assign push    = inflight_q;
  assign pop     = wr_valid & wr_ready;
  assign last_rd = (rd_cnt_q == len_q - LEN_W'(1));
  assign last_wr = (wr_cnt_q == len_q - LEN_W'(1));

  // Read credit counts FIFO occupancy after this cycle's pop, so a draining sink keeps
  // one read per cycle while a stalled sink caps outstanding words at the FIFO depth.
  always_comb begin
    credit_used = (CntW+1)'(count_q) - (CntW+1)'(pop) + (CntW+1)'(inflight_q);
    rd_en       = (state_q == StRun) && (credit_used < (CntW+1)'(FifoDepth));
  end

  // Next-state logic for the job FSM, descriptor capture and address counters.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          src_d    = cfg_src_base;
          dst_d    = cfg_dst_base;
          len_d    = cfg_len;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = (cfg_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + LEN_W'(1);
          if (last_rd) state_d = StDrain;
        end
        if (pop) wr_cnt_d = wr_cnt_q + LEN_W'(1);
      end
      StDrain: begin
        if (pop) begin
          wr_cnt_d = wr_cnt_q + LEN_W'(1);
          if (last_wr) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output FIFO: push lane results the cycle read data returns, pop on write handshake.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = lane_out;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  // State registers; reset drops any in-flight job and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FifoDepth; i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      inflight_q <= rd_en;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fifo_mem_q <= fifo_mem_d;
    end
  end

endmodule

// File: tb/tb_swish_act_scheduler.sv
// Scoreboard bench for swish_act_scheduler: SRAM model, expected-write queue, job scenarios.
module tb_swish_act_scheduler;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned DataW  = WIDTH * LANES;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DataW-1:0]  data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_src_base = '0;
  logic [ADDR_W-1:0] cfg_dst_base = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DataW-1:0]  rd_data = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [DataW-1:0]  wr_data;

  int n_vec = 0;
  int n_err = 0;

  logic [DataW-1:0]  sram [1 << ADDR_W];
  exp_t              exp_q [$];
  int                rd_seen = 0;
  int                wr_seen = 0;
  logic [ADDR_W-1:0] cur_src = '0;
  logic [ADDR_W-1:0] cur_dst = '0;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DataW-1:0]  prev_data = '0;

  swish_act_scheduler u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_src_base(cfg_src_base),
    .cfg_dst_base(cfg_dst_base),
    .cfg_len     (cfg_len),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference hard-swish: x * clamp(x+3, 0, 6) / 6, division truncating toward zero.
  function automatic logic [DataW-1:0] model_word(input logic [DataW-1:0] w);
    logic [DataW-1:0]        res;
    logic signed [WIDTH-1:0] el;
    int                      x, t, q;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      el = w[i*WIDTH +: WIDTH];
      x  = int'(el);
      t  = x + 3;
      if (t < 0) t = 0;
      if (t > 6) t = 6;
      q  = (x * t) / 6;
      res[i*WIDTH +: WIDTH] = q[WIDTH-1:0];
    end
    return res;
  endfunction

  // Synchronous SRAM read port: data one cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= sram[rd_addr];
  end

  // Monitor: score reads into the queue, compare writes, check stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("wr_hold_valid", 64'(wr_valid), 64'd1);
        check("wr_hold_addr", 64'(wr_addr), 64'(prev_addr));
        check("wr_hold_data", 64'(wr_data), 64'(prev_data));
      end
      if (rd_en) begin
        e.addr = cur_src + ADDR_W'(rd_seen);
        check("rd_addr", 64'(rd_addr), 64'(e.addr));
        e.data = model_word(sram[e.addr]);
        e.addr = cur_dst + ADDR_W'(rd_seen);
        exp_q.push_back(e);
        rd_seen++;
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", 64'(wr_data), 64'(e.data));
        end
        wr_seen++;
      end
      if (rd_seen - wr_seen > 2) check("outstanding", 64'(rd_seen - wr_seen), 64'd2);
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_wr_valid"}, 64'(wr_valid), 64'd0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
  endtask

  // mode 0: wr_ready=1; mode 1: toggles each cycle; mode 2: low for 20 cycles then high.
  // exp_done < 0 skips the exact completion-cycle check.
  task automatic run_job(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                         input int len, input int mode, input bit hold_cfg,
                         input int exp_done);
    int cyc;
    int done_cyc;
    cur_src      = src;
    cur_dst      = dst;
    rd_seen      = 0;
    wr_seen      = 0;
    cfg_src_base = src;
    cfg_dst_base = dst;
    cfg_len      = LEN_W'(len);
    cfg_valid    = 1'b1;
    wr_ready     = (mode != 2);
    check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    tick();
    if (!hold_cfg) cfg_valid = 1'b0;
    cyc      = 1;
    done_cyc = -1;
    while (cyc < 300) begin
      if (done) begin
        done_cyc = cyc;
        cfg_valid = 1'b0;
        break;
      end
      if (hold_cfg && cyc == 3) check("cfg_ready_busy", 64'(cfg_ready), 64'd0);
      if (mode == 2 && cyc == 20) check("stall_reads", 64'(rd_seen), 64'd2);
      case (mode)
        1:       wr_ready = cyc[0];
        2:       wr_ready = (cyc >= 20);
        default: wr_ready = 1'b1;
      endcase
      tick();
      cyc++;
    end
    if (done_cyc < 0) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      if (exp_done >= 0) check("done_cycle", 64'(done_cyc), 64'(exp_done));
      check("busy_in_done", 64'(busy), 64'd1);
      tick();
      check("done_pulse", 64'(done), 64'd0);
      check("busy_after", 64'(busy), 64'd0);
      check("cfg_ready_after", 64'(cfg_ready), 64'd1);
    end
    check("rd_count", 64'(rd_seen), 64'(len));
    check("wr_count", 64'(wr_seen), 64'(len));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    wr_ready = 1'b0;
    tick();
  endtask

  task automatic fill_random(input logic [ADDR_W-1:0] base, input int len);
    for (int i = 0; i < len; i++) sram[base + ADDR_W'(i)] = DataW'($urandom);
  endtask

  initial begin
    logic [DataW-1:0] pat;
    for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = '0;

    // Reset state.
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Fixed pattern: lanes {3,-3,2,10} -> {3,0,1,10}, done 7 cycles after accept.
    pat = {8'sd10, 8'sd2, -8'sd3, 8'sd3};
    for (int i = 0; i < 4; i++) sram[12'h010 + i] = pat;
    run_job(12'h010, 12'h100, 4, 0, 1'b0, 7);

    // Zero-length job: no SRAM traffic, done the cycle after accept.
    run_job(12'h020, 12'h200, 0, 0, 1'b0, 1);

    // Toggling write backpressure.
    fill_random(12'h040, 6);
    run_job(12'h040, 12'h300, 6, 1, 1'b0, -1);

    // Long write stall then release.
    fill_random(12'h080, 5);
    run_job(12'h080, 12'h400, 5, 2, 1'b0, -1);

    // Read address wrap with cfg_valid held through the job.
    fill_random(12'hFFE, 2);
    fill_random(12'h000, 2);
    run_job(12'hFFE, 12'h500, 4, 0, 1'b1, 7);

    // Asynchronous reset mid-RUN, then a clean job.
    fill_random(12'h0C0, 8);
    cur_src      = 12'h0C0;
    cur_dst      = 12'h600;
    rd_seen      = 0;
    wr_seen      = 0;
    cfg_src_base = 12'h0C0;
    cfg_dst_base = 12'h600;
    cfg_len      = LEN_W'(8);
    cfg_valid    = 1'b1;
    wr_ready     = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    check("mid_run_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    fill_random(12'h0E0, 3);
    run_job(12'h0E0, 12'h700, 3, 0, 1'b0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
